// File: rtl/bin_threshold_ctrl.sv
// bin_threshold_ctrl: owns the 8-bit binarization threshold for the camera
// binarize stage. Two raw push-buttons (debounced, long-press auto-repeat) and
// a host config port update a pending value that is transferred to the pixel
// datapath.
// Optional feature macro: BIN_THR_FRAME_SYNC_EN -- when defined, the pending
// value is applied only at frame boundaries (rising edge of frame_vsync); when
// undefined, the pending value is applied every cycle and frame_vsync is unused.
module bin_threshold_ctrl #(
  parameter int         DEB_CYC  = 1_000_000,
  parameter int         HOLD_CYC = 25_000_000,
  parameter int         RPT_CYC  = 5_000_000,
  parameter logic [7:0] THR_INIT = 8'd120,
  parameter logic [7:0] THR_MIN  = 8'd0,
  parameter logic [7:0] THR_MAX  = 8'd255
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_up_n,
  input  logic       key_dn_n,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_data,
  output logic       cfg_ready,
  input  logic       frame_vsync,
  output logic [7:0] bin_threshold,
  output logic       thr_update
);

  localparam logic [31:0] DEB_LAST  = 32'(DEB_CYC - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYC - 1);
  localparam logic [31:0] RPT_LAST  = 32'(RPT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEB  = 2'd1,
    S_HOLD = 2'd2,
    S_RPT  = 2'd3
  } key_state_t;

  // Index 0 is the up key, index 1 is the down key.
  logic [1:0]  key_p0;
  logic [1:0]  key_p1;
  logic [1:0]  pressed;
  key_state_t  st_q  [2];
  logic [31:0] cnt_q [2];
  logic [1:0]  step_q;

  logic [7:0]  pend_q;
  logic [7:0]  pend_nxt;
  logic        cfg_pend_q;
  logic        cfg_accept;
  logic        apply;

  function automatic logic [7:0] clamp_thr(input logic [7:0] v);
    if (v < THR_MIN) return THR_MIN;
    if (v > THR_MAX) return THR_MAX;
    return v;
  endfunction

  function automatic logic [7:0] inc_sat(input logic [7:0] v);
    return (v == THR_MAX) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] dec_sat(input logic [7:0] v);
    return (v == THR_MIN) ? v : v - 8'd1;
  endfunction

  // Two-flop synchronizers for the raw buttons; released (1) out of reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_p0 <= 2'b11;
      key_p1 <= 2'b11;
    end else begin
      key_p0 <= {key_dn_n, key_up_n};
      key_p1 <= key_p0;
    end
  end

  assign pressed = ~key_p1;

`ifdef BIN_THR_FRAME_SYNC_EN
  logic vs_p0;
  logic vs_p1;
  logic vs_p2;

  // Synchronize vsync and keep one extra flop for rising-edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_p0 <= 1'b0;
      vs_p1 <= 1'b0;
      vs_p2 <= 1'b0;
    end else begin
      vs_p0 <= frame_vsync;
      vs_p1 <= vs_p0;
      vs_p2 <= vs_p1;
    end
  end

  assign apply = vs_p1 & ~vs_p2;
`else
  logic unused_vsync;
  assign unused_vsync = frame_vsync;
  assign apply        = 1'b1;
`endif

  // Per-key debounce / hold / auto-repeat FSMs with registered step pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < 2; k++) begin
        st_q[k]  <= S_IDLE;
        cnt_q[k] <= '0;
      end
      step_q <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        step_q[k] <= 1'b0;
        case (st_q[k])
          S_IDLE: begin
            cnt_q[k] <= '0;
            if (pressed[k]) st_q[k] <= S_DEB;
          end
          S_DEB: begin
            if (!pressed[k]) begin
              st_q[k]  <= S_IDLE;
              cnt_q[k] <= '0;
            end else if (cnt_q[k] == DEB_LAST) begin
              step_q[k] <= 1'b1;
              cnt_q[k]  <= '0;
              st_q[k]   <= S_HOLD;
            end else begin
              cnt_q[k] <= cnt_q[k] + 32'd1;
            end
          end
          S_HOLD: begin
            if (!pressed[k]) begin
              st_q[k]  <= S_IDLE;
              cnt_q[k] <= '0;
            end else if (cnt_q[k] == HOLD_LAST) begin
              step_q[k] <= 1'b1;
              cnt_q[k]  <= '0;
              st_q[k]   <= S_RPT;
            end else begin
              cnt_q[k] <= cnt_q[k] + 32'd1;
            end
          end
          S_RPT: begin
            if (!pressed[k]) begin
              st_q[k]  <= S_IDLE;
              cnt_q[k] <= '0;
            end else if (cnt_q[k] == RPT_LAST) begin
              step_q[k] <= 1'b1;
              cnt_q[k]  <= '0;
            end else begin
              cnt_q[k] <= cnt_q[k] + 32'd1;
            end
          end
          default: begin
            st_q[k]  <= S_IDLE;
            cnt_q[k] <= '0;
          end
        endcase
      end
    end
  end

  assign cfg_accept = cfg_valid & cfg_ready;

  // Next pending value: host write wins and drops key steps; up+down cancel.
  always_comb begin
    pend_nxt = pend_q;
    if (cfg_accept)            pend_nxt = clamp_thr(cfg_data);
    else if (step_q == 2'b11)  pend_nxt = pend_q;
    else if (step_q[0])        pend_nxt = inc_sat(pend_q);
    else if (step_q[1])        pend_nxt = dec_sat(pend_q);
  end

  // Pending register and host handshake; a new accept outranks a same-cycle apply.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_q     <= THR_INIT;
      cfg_pend_q <= 1'b0;
    end else begin
      pend_q <= pend_nxt;
      if (cfg_accept)  cfg_pend_q <= 1'b1;
      else if (apply)  cfg_pend_q <= 1'b0;
    end
  end

  assign cfg_ready = ~cfg_pend_q;

  // Transfer pending value to the datapath and flag actual changes.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bin_threshold <= THR_INIT;
      thr_update    <= 1'b0;
    end else if (apply) begin
      bin_threshold <= pend_q;
      thr_update    <= (pend_q != bin_threshold);
    end else begin
      thr_update    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bin_threshold_ctrl.sv
// Scoreboard bench for bin_threshold_ctrl (sim parameters DEB=4, HOLD=20,
// RPT=8, THR_MAX=200). Expectations follow BIN_THR_FRAME_SYNC_EN if defined.
module tb_bin_threshold_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key_up_n = 1'b1;
  logic       key_dn_n = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'd0;
  logic       cfg_ready;
  logic       frame_vsync = 1'b0;
  logic [7:0] bin_threshold;
  logic       thr_update;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  bin_threshold_ctrl #(
    .DEB_CYC (4),
    .HOLD_CYC(20),
    .RPT_CYC (8),
    .THR_INIT(8'd120),
    .THR_MIN (8'd0),
    .THR_MAX (8'd200)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .key_up_n     (key_up_n),
    .key_dn_n     (key_dn_n),
    .cfg_valid    (cfg_valid),
    .cfg_data     (cfg_data),
    .cfg_ready    (cfg_ready),
    .frame_vsync  (frame_vsync),
    .bin_threshold(bin_threshold),
    .thr_update   (thr_update)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every thr_update pulse must match the next scoreboard entry.
  always @(negedge sys_clk) begin
    if (sys_rst_n && thr_update) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update: got %0d expected no update", bin_threshold);
      end else begin
        check("update_value", int'(bin_threshold), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic vsync_pulse();
    frame_vsync = 1'b1;
    cyc(4);
    frame_vsync = 1'b0;
    cyc(6);
  endtask

  task automatic cfg_write(input logic [7:0] d);
    cfg_data  = d;
    cfg_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(3);
    @(negedge sys_clk);
    check("rst_threshold", int'(bin_threshold), 120);
    check("rst_update", int'(thr_update), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    cyc(1);
    sys_rst_n = 1'b1;
    cyc(3);

    // Short up tap: one step 120 -> 121
`ifndef BIN_THR_FRAME_SYNC_EN
    exp_q.push_back(8'd121);
`endif
    key_up_n = 1'b0;
    cyc(10);
    key_up_n = 1'b1;
    cyc(10);
`ifdef BIN_THR_FRAME_SYNC_EN
    @(negedge sys_clk);
    check("no_apply_before_vsync", int'(bin_threshold), 120);
    exp_q.push_back(8'd121);
`endif
    vsync_pulse();
    @(negedge sys_clk);
    check("tap_up", int'(bin_threshold), 121);

    // Down glitch shorter than debounce: no step
    cyc(1);
    key_dn_n = 1'b0;
    cyc(3);
    key_dn_n = 1'b1;
    cyc(10);
    vsync_pulse();
    @(negedge sys_clk);
    check("glitch_dn", int'(bin_threshold), 121);

    // Long hold of 60 cycles: six steps 121 -> 127
`ifndef BIN_THR_FRAME_SYNC_EN
    for (int v = 122; v <= 127; v++) exp_q.push_back(8'(v));
`endif
    cyc(1);
    key_up_n = 1'b0;
    cyc(60);
    key_up_n = 1'b1;
    cyc(10);
`ifdef BIN_THR_FRAME_SYNC_EN
    exp_q.push_back(8'd127);
`endif
    vsync_pulse();
    @(negedge sys_clk);
    check("hold_repeat", int'(bin_threshold), 127);

    // Host write above THR_MAX clamps to 200; key up then saturates
    exp_q.push_back(8'd200);
    cyc(1);
    cfg_write(8'd250);
    @(negedge sys_clk);
    check("cfg_ready_low_after_accept", int'(cfg_ready), 0);
`ifdef BIN_THR_FRAME_SYNC_EN
    cyc(5);
    @(negedge sys_clk);
    check("cfg_ready_low_until_apply", int'(cfg_ready), 0);
`endif
    cyc(1);
    key_up_n = 1'b0;
    cyc(10);
    key_up_n = 1'b1;
    cyc(10);
    vsync_pulse();
    @(negedge sys_clk);
    check("cfg_ready_after_apply", int'(cfg_ready), 1);
    check("cfg_clamp_max", int'(bin_threshold), 200);

    // Move to THR_MIN, then down tap saturates and up+down cancel
    exp_q.push_back(8'd0);
    cyc(1);
    cfg_write(8'd0);
    cyc(3);
    vsync_pulse();
    @(negedge sys_clk);
    check("cfg_zero", int'(bin_threshold), 0);
    cyc(1);
    key_dn_n = 1'b0;
    cyc(10);
    key_dn_n = 1'b1;
    cyc(10);
    vsync_pulse();
    @(negedge sys_clk);
    check("dn_sat_min", int'(bin_threshold), 0);
    cyc(1);
    key_up_n = 1'b0;
    key_dn_n = 1'b0;
    cyc(10);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    cyc(10);
    vsync_pulse();
    @(negedge sys_clk);
    check("up_dn_cancel", int'(bin_threshold), 0);

    // Host write 77
    exp_q.push_back(8'd77);
    cyc(1);
    cfg_write(8'd77);
`ifndef BIN_THR_FRAME_SYNC_EN
    @(negedge sys_clk);
    check("cfg77_not_yet", int'(bin_threshold), 0);
    @(negedge sys_clk);
    check("cfg77_two_cycles", int'(bin_threshold), 77);
`else
    vsync_pulse();
    @(negedge sys_clk);
    check("cfg77_vsync", int'(bin_threshold), 77);
`endif

    // Reset asserted mid-hold, key held through reset release
`ifndef BIN_THR_FRAME_SYNC_EN
    exp_q.push_back(8'd78);
    exp_q.push_back(8'd79);
`endif
    cyc(1);
    key_up_n = 1'b0;
    cyc(30);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("rst_mid_hold_threshold", int'(bin_threshold), 120);
    check("rst_mid_hold_update", int'(thr_update), 0);
    check("rst_mid_hold_ready", int'(cfg_ready), 1);
    cyc(2);
`ifndef BIN_THR_FRAME_SYNC_EN
    exp_q.push_back(8'd121);
`endif
    sys_rst_n = 1'b1;
    cyc(10);
    key_up_n = 1'b1;
    cyc(6);
`ifdef BIN_THR_FRAME_SYNC_EN
    exp_q.push_back(8'd121);
`endif
    vsync_pulse();
    @(negedge sys_clk);
    check("redebounce_after_reset", int'(bin_threshold), 121);

    cyc(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
